// File: rtl/rv_mem_pkg.sv
// Shared types for the RV32I unified-memory arbiter: requester ownership and read-tag format.
package rv_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/rv_mem_tag_pipe.sv
// DEPTH-stage shift register of read tags with asynchronous active-low clear.
module rv_mem_tag_pipe
    import rv_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '{default: '0};
        end else begin
            pipe_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/rv_mem_arbiter.sv
// Fetch/load-store arbiter for a single-port BRAM with fixed-latency read-tag tracking.
// Define RV_MEM_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module rv_mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MEM_AW  = 12,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              sysclk,
    input  logic              sysreset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    tag_t        push_tag;
    tag_t        pop_tag;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;
    logic        unused_addr_bits;

`ifdef RV_MEM_ARB_RR_EN
    owner_e last_winner_q;
    owner_e last_winner_d;

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (sysreset) begin
            if (i_req && d_req) begin
                // Contention goes to whichever port did not win the previous accept.
                d_gnt = (last_winner_q == OWN_FETCH);
                i_gnt = (last_winner_q == OWN_DATA);
            end else begin
                d_gnt = d_req;
                i_gnt = i_req;
            end
        end
    end

    always_comb begin
        last_winner_d = last_winner_q;
        if (d_gnt)      last_winner_d = OWN_DATA;
        else if (i_gnt) last_winner_d = OWN_FETCH;
    end

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) last_winner_q <= OWN_FETCH;
        else           last_winner_q <= last_winner_d;
    end
`else
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (sysreset) begin
            d_gnt = d_req;
            i_gnt = i_req && !d_req;
        end
    end
`endif

    always_comb begin
        mem_en    = i_gnt || d_gnt;
        mem_we    = (d_gnt && d_we) ? d_be : '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (sysreset) begin
            mem_addr  = d_gnt ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        push_tag.valid = (i_gnt || d_gnt) && !(d_gnt && d_we);
        push_tag.owner = d_gnt ? OWN_DATA : OWN_FETCH;
    end

    rv_mem_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk_i  (sysclk),
        .rst_ni (sysreset),
        .tag_i  (push_tag),
        .tag_o  (pop_tag)
    );

    // Response data passes straight through in its valid cycle and is then held in a flop.
    assign i_rvalid = pop_tag.valid && (pop_tag.owner == OWN_FETCH);
    assign d_rvalid = pop_tag.valid && (pop_tag.owner == OWN_DATA);
    assign i_rdata  = i_rvalid ? mem_rdata : i_rdata_q;
    assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_rdata_q <= i_rdata;
            d_rdata_q <= d_rdata;
        end
    end

    assign unused_addr_bits = ^{i_addr[1:0], i_addr[ADDR_W-1:MEM_AW+2],
                                d_addr[1:0], d_addr[ADDR_W-1:MEM_AW+2]};

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench: three arbiter instances (MEM_LAT 1..3) share stimulus, each with its own BRAM model.
module tb_rv_mem_arbiter;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;

    logic        i_gnt_w    [1:3];
    logic        i_rvalid_w [1:3];
    logic [31:0] i_rdata_w  [1:3];
    logic        d_gnt_w    [1:3];
    logic        d_rvalid_w [1:3];
    logic [31:0] d_rdata_w  [1:3];
    logic        mem_en_w   [1:3];
    logic [3:0]  mem_we_w   [1:3];
    logic [11:0] mem_addr_w [1:3];
    logic [31:0] mem_wdata_w[1:3];
    logic [31:0] mem_rdata_w[1:3];

    int n_pass  = 0;
    int n_total = 0;

    always #5 sysclk = ~sysclk;

    for (genvar L = 1; L <= 3; L++) begin : g_lat
        logic [31:0] mem  [0:63];
        logic [31:0] rd_q [L];

        initial begin
            for (int w = 0; w < 64; w++) mem[w] = 32'h0;
            mem[0] = 32'h0070_0093;
            mem[1] = 32'hAABB_0001;
            mem[2] = 32'hCCDD_0002;
            mem[4] = 32'h1234_5678;
            mem[8] = 32'h1122_3344;
        end

        always @(posedge sysclk) begin
            if (mem_en_w[L]) begin
                rd_q[0] <= mem[mem_addr_w[L][5:0]];
                for (int b = 0; b < 4; b++)
                    if (mem_we_w[L][b])
                        mem[mem_addr_w[L][5:0]][b*8 +: 8] <= mem_wdata_w[L][b*8 +: 8];
            end
            for (int k = 1; k < L; k++) rd_q[k] <= rd_q[k-1];
        end

        assign mem_rdata_w[L] = rd_q[L-1];

        rv_mem_arbiter #(
            .ADDR_W  (32),
            .MEM_AW  (12),
            .MEM_LAT (L)
        ) u_dut (
            .sysclk    (sysclk),
            .sysreset  (sysreset),
            .i_req     (i_req),
            .i_addr    (i_addr),
            .i_gnt     (i_gnt_w[L]),
            .i_rvalid  (i_rvalid_w[L]),
            .i_rdata   (i_rdata_w[L]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_be      (d_be),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt_w[L]),
            .d_rvalid  (d_rvalid_w[L]),
            .d_rdata   (d_rdata_w[L]),
            .mem_en    (mem_en_w[L]),
            .mem_we    (mem_we_w[L]),
            .mem_addr  (mem_addr_w[L]),
            .mem_wdata (mem_wdata_w[L]),
            .mem_rdata (mem_rdata_w[L])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle(input int n);
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        for (int c = 0; c < n; c++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        sysreset = 1'b0;
        i_req = 1'b1; i_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h8; d_wdata = 32'hFFFF_FFFF;
        #2;
        chk("rst_i_gnt",     i_gnt_w[1],     0);
        chk("rst_d_gnt",     d_gnt_w[1],     0);
        chk("rst_mem_en",    mem_en_w[1],    0);
        chk("rst_mem_we",    mem_we_w[1],    0);
        chk("rst_mem_addr",  mem_addr_w[1],  0);
        chk("rst_mem_wdata", mem_wdata_w[1], 0);
        chk("rst_i_rdata",   i_rdata_w[1],   0);
        chk("rst_d_rvalid",  d_rvalid_w[1],  0);
        tick(); tick();

        // Fetch only, word 0
        sysreset = 1'b1;
        d_req = 1'b0; d_we = 1'b0; i_addr = 32'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("fetch_i_gnt",    i_gnt_w[1],    1);
            chk("fetch_mem_addr", mem_addr_w[1], 0);
            chk("fetch_mem_en",   mem_en_w[1],   1);
            tick();
            if (c == 2) i_req = 1'b0;
            chk("fetch_i_rvalid", i_rvalid_w[1], 1);
            chk("fetch_i_rdata",  i_rdata_w[1],  32'h0070_0093);
            chk("fetch_d_rvalid", d_rvalid_w[1], 0);
        end
        tick();
        chk("fetch_rvalid_end", i_rvalid_w[1], 0);

        // Conflict under default priority: data load 0x10 beats fetch 0x4
        i_req = 1'b1; i_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        #1;
        chk("conf_d_gnt",    d_gnt_w[1],    1);
        chk("conf_i_gnt",    i_gnt_w[1],    0);
        chk("conf_mem_addr", mem_addr_w[1], 4);
        chk("conf_mem_we",   mem_we_w[1],   0);
        tick();
        d_req = 1'b0;
        #1;
        chk("conf_d_rvalid", d_rvalid_w[1], 1);
        chk("conf_d_rdata",  d_rdata_w[1],  32'h1234_5678);
        chk("conf_i_gnt2",   i_gnt_w[1],    1);
        chk("conf_i_rvalid", i_rvalid_w[1], 0);
        tick();
        i_req = 1'b0;
        chk("conf_i_rdata",  i_rdata_w[1],  32'hAABB_0001);
        chk("conf_d_hold",   d_rdata_w[1],  32'h1234_5678);
        chk("conf_d_rv_off", d_rvalid_w[1], 0);

        // Store byte 1 of word 8, then load it back
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 32'h20; d_wdata = 32'h0000_AB00;
        #1;
        chk("st_mem_we",    mem_we_w[1],    4'b0010);
        chk("st_mem_wdata", mem_wdata_w[1], 32'h0000_AB00);
        chk("st_mem_addr",  mem_addr_w[1],  8);
        tick();
        d_we = 1'b0;
        #1;
        chk("st_no_rvalid", d_rvalid_w[1], 0);
        chk("ld_mem_we",    mem_we_w[1],   0);
        tick();
        d_req = 1'b0;
        chk("ld_d_rvalid",  d_rvalid_w[1], 1);
        chk("ld_d_rdata",   d_rdata_w[1],  32'h1122_AB44);

        // Misaligned data address and aliased fetch address
        d_req = 1'b1; d_addr = 32'h23;
        #1;
        chk("mis_mem_addr", mem_addr_w[1], 8);
        tick();
        d_req = 1'b0;
        chk("mis_d_rdata",  d_rdata_w[1],  32'h1122_AB44);
        i_req = 1'b1; i_addr = 32'h4004;
        #1;
        chk("alias_mem_addr", mem_addr_w[1], 1);
        tick();
        i_req = 1'b0;
        chk("alias_i_rdata",  i_rdata_w[1],  32'hAABB_0001);

        // Both requesting for 4 cycles, previous winner is fetch
        i_req = 1'b1; i_addr = 32'hC;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        for (int c = 0; c < 4; c++) begin
            #1;
`ifdef RV_MEM_ARB_RR_EN
            chk("arb_d_gnt", d_gnt_w[1], (c % 2 == 0) ? 1 : 0);
            chk("arb_i_gnt", i_gnt_w[1], (c % 2 == 0) ? 0 : 1);
`else
            chk("arb_d_gnt", d_gnt_w[1], 1);
            chk("arb_i_gnt", i_gnt_w[1], 0);
`endif
            tick();
        end
        idle(4);

        // MEM_LAT=3: I@0, D@8, I@4 back-to-back
        i_req = 1'b1; i_addr = 32'h0;
        tick();
        i_req = 1'b0; d_req = 1'b1; d_addr = 32'h8;
        chk("l3_none0", i_rvalid_w[3] | d_rvalid_w[3], 0);
        tick();
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h4;
        chk("l3_none1", i_rvalid_w[3] | d_rvalid_w[3], 0);
        tick();
        i_req = 1'b0;
        chk("l3_i0_rvalid", i_rvalid_w[3], 1);
        chk("l3_i0_drv",    d_rvalid_w[3], 0);
        chk("l3_i0_rdata",  i_rdata_w[3],  32'h0070_0093);
        tick();
        chk("l3_d_rvalid",  d_rvalid_w[3], 1);
        chk("l3_d_irv",     i_rvalid_w[3], 0);
        chk("l3_d_rdata",   d_rdata_w[3],  32'hCCDD_0002);
        tick();
        chk("l3_i1_rvalid", i_rvalid_w[3], 1);
        chk("l3_i1_rdata",  i_rdata_w[3],  32'hAABB_0001);
        tick();
        chk("l3_end", i_rvalid_w[3] | d_rvalid_w[3], 0);
        idle(3);

        // MEM_LAT=2: accept a read, assert reset mid-cycle afterwards
        i_req = 1'b1; i_addr = 32'h0;
        tick();
        d_req = 1'b1;
        #2;
        sysreset = 1'b0;
        #1;
        chk("mid_i_gnt",    i_gnt_w[2],    0);
        chk("mid_d_gnt",    d_gnt_w[2],    0);
        chk("mid_mem_en",   mem_en_w[2],   0);
        chk("mid_rvalid2",  i_rvalid_w[2] | d_rvalid_w[2], 0);
        chk("mid_rvalid1",  i_rvalid_w[1], 0);
        chk("mid_i_rdata1", i_rdata_w[1],  0);
        tick();
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h4;
        #2;
        sysreset = 1'b1;
        #1;
        chk("rel_i_gnt",  i_gnt_w[2],  1);
        chk("rel_mem_en", mem_en_w[2], 1);
        tick();
        i_req = 1'b0;
        chk("rel_no_rv", i_rvalid_w[2] | d_rvalid_w[2], 0);
        tick();
        chk("rel_i_rvalid", i_rvalid_w[2], 1);
        chk("rel_i_rdata",  i_rdata_w[2],  32'hAABB_0001);
        tick();
        chk("rel_end", i_rvalid_w[2] | d_rvalid_w[2], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one single-port synchronous BRAM between the RV32I core's instruction-fetch port and its load/store port.
- Arbitrates per cycle and drives the memory port.
- Tracks in-flight reads through a fixed-latency tag pipeline, so each read response returns only to the requester that issued it.
- Sits between the core and the unified instruction/data memory inside the top-level wrapper.

Parameters:
- ADDR_W, 32, byte-address width of both requester ports.
- MEM_AW, 12, word-address width of the BRAM port (mem_addr = addr[MEM_AW+1:2]).
- MEM_LAT, 1, BRAM read latency in cycles; legal range 1..4.

Ports:
- sysclk  in  1  system clock, rising edge.
- sysreset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request valid.
- i_addr  in  ADDR_W  fetch byte address (word aligned).
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  32  fetch read data (the instruction).
- d_req  in  1  data request valid.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, already lane-aligned.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  load data (full word; the core extracts bytes).
- mem_en  out  1  BRAM enable.
- mem_we  out  4  BRAM byte write enables.
- mem_addr  out  MEM_AW  BRAM word address.
- mem_wdata  out  32  BRAM write data.
- mem_rdata  in  32  BRAM read data, valid MEM_LAT cycles after a read enable.

Behaviour:
- Reset (sysreset=0): the following are held at 0 asynchronously: tag pipeline, valid pipeline, last-winner register, i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we.
- Reset (sysreset=0): mem_addr, mem_wdata, i_rdata and d_rdata are driven 0.
- Grant is combinational from req and the last-winner state. At most one of i_gnt/d_gnt is high per cycle. gnt is never high without the matching req.
- A transaction is accepted on a rising edge where req&gnt=1. The requester may change addr/data in the next cycle.
- The memory port is driven combinationally from the granted requester in the accept cycle:
  - mem_en=1.
  - mem_addr = granted addr[MEM_AW+1:2].
  - mem_we = d_be when a store is granted, else 0.
  - mem_wdata = d_wdata.
- If no request is granted: mem_en=0, mem_we=0.
- Fixed priority (default): data over fetch. If d_req=1 then d_gnt=1 and i_gnt=0, otherwise i_gnt=i_req.
- Tag pipeline: MEM_LAT-deep shift register of {valid, owner}. A read accept pushes {1, owner}; a store or idle cycle pushes {0, x}.
- At the pipeline output, when valid=1:
  - owner=fetch: i_rvalid=1 for exactly one cycle, i_rdata=mem_rdata.
  - owner=data: d_rvalid=1 for exactly one cycle, d_rdata=mem_rdata.
- rdata of the non-addressed requester holds its previous value.
- Read latency from accept edge to rvalid is exactly MEM_LAT cycles. With MEM_LAT=1, rvalid is high in the cycle after acceptance.
- Throughput is one accept per cycle. Back-to-back reads from mixed owners return in issue order with no bubbles.
- Stores produce no response.
- A store followed immediately by a load to the same word returns the new data; this relies on BRAM read-after-write ordering across cycles.
- Simultaneous i_req and d_req resolve per the active policy. The losing request must be held stable by the requester until granted.
- Misaligned addr[1:0] are ignored (word access). Addresses above 2^(MEM_AW+2) alias (upper bits dropped).
- Reset mid-operation: in-flight reads are discarded and no rvalid follows reset release. The first accept is possible in the first cycle after release.

Optional Feature:
- Macro: RV_MEM_ARB_RR_EN.
- When defined: round-robin arbitration.
  - A 1-bit last_winner register is updated on every accept.
  - When both request, the port that did not win last is granted.
  - With a single requester, that requester is granted regardless of last_winner.
  - last_winner resets to fetch, so data wins the first conflict.
- When not defined: fixed data-over-fetch priority, and no last_winner flop is synthesized.

Decomposition:
- Package rv_mem_pkg holds:
  - typedef owner_e {OWN_FETCH=1'b0, OWN_DATA=1'b1}.
  - packed struct tag_t {valid, owner}.
  - constant WORD_BYTES=4.
- One natural sub-module: rv_mem_tag_pipe. It is a parameterized MEM_LAT-deep shift register of tag_t with async active-low clear, and is reused by any future second memory port.

Test Plan:
- Reset, then fetch only. i_req=1, i_addr=0x0000_0000 for 3 cycles, MEM_LAT=1, memory preloaded 0x00700093 at word 0. Required:
  - i_gnt=1 every cycle.
  - mem_addr=0.
  - i_rvalid=1 starting the next cycle with i_rdata=0x00700093.
  - d_rvalid=0 throughout.
- Conflict, fixed priority. i_req=1 with i_addr=0x4, and d_req=1 with d_we=0, d_addr=0x10, same cycle. Required:
  - d_gnt=1, i_gnt=0, mem_addr=0x4.
  - Next cycle: d_rvalid=1, and i_gnt=1 once d_req drops.
- Store then load. Store d_be=4'b0010, d_addr=0x20, d_wdata=0x0000_AB00 to word initially 0x11223344, then load 0x20. Required:
  - mem_we=4'b0010 on the store cycle.
  - The load returns d_rdata=0x1122AB44.
  - No d_rvalid for the store.
- MEM_LAT=3 pipelined mix. Accept sequence I@0x0, D@0x8, I@0x4 back-to-back. Required:
  - rvalids arrive on cycles +3, +4, +5 as i, d, i.
  - Data equals the contents of words 0, 2, 1 respectively.
- Reset mid-flight. MEM_LAT=2, accept a read, then drive sysreset=0 one cycle later (asynchronously, between edges). Required:
  - All gnt, rvalid and mem_en outputs drop immediately.
  - No rvalid appears after release.
- With RV_MEM_ARB_RR_EN defined: i_req and d_req held high for 4 cycles. Required: grants alternate D, I, D, I.
